entropy_reader: RTL and testbench
=================================

Name: entropy_reader

Overview:
Consumer-side companion to the 8-bit random generator. It samples the generator's output byte stream at a fixed decimation rate and discards a warm-up run. It applies a repetition-count health test and buffers accepted bytes in a FIFO. The Nios CPU drains the FIFO through a PIO-style valid/ack handshake. It sits between the random generator output and a new Nios PIO input, and feeds entropy for key/mnemonic generation.

Parameters:
DEPTH, 16, FIFO depth in bytes (power of two, >=2)
SAMPLE_DIV, 8, clocks between samples (>=2)
WARMUP, 32, samples discarded after enable or fault clear (>=1)
REP_LIMIT, 4, number of consecutive identical samples that trips the fault (>=2)

Ports:
i_clk  in  1  system clock (CLOCK_50 domain)
i_reset  in  1  synchronous, active-high reset
i_enable  in  1  level; 1 = collect, 0 = idle
i_data  in  8  random generator output byte
i_rd_ack  in  1  one-cycle pulse; pops FIFO head
i_fault_clr  in  1  one-cycle pulse; leaves FAULT
o_rd_data  out  8  FIFO head byte; valid only when o_rd_valid=1
o_rd_valid  out  1  FIFO not empty
o_count  out  clog2(DEPTH)+1  FIFO occupancy
o_full  out  1  occupancy == DEPTH
o_fault  out  1  health test tripped
o_state  out  2  IDLE=0, WARMUP=1, COLLECT=2, FAULT=3

Behaviour:
- Reset: state IDLE. o_rd_data=0, o_rd_valid=0, o_count=0, o_full=0, o_fault=0. Divider, warm-up count, repetition count and previous-sample register are all 0.
- Divider: free-runs 0..SAMPLE_DIV-1 in WARMUP and COLLECT, and is held at 0 otherwise. A sample strobe occurs on the cycle the divider equals SAMPLE_DIV-1. i_data is registered on that edge.
- Repetition test: runs on every strobe in WARMUP and COLLECT.
  - If the sample equals the previous sample, rep increments. Otherwise rep=1.
  - The previous-sample register is updated on every strobe.
  - rep reaching REP_LIMIT trips the fault.
- State transitions:
  - IDLE -> WARMUP when i_enable=1. Warm-up count, rep and divider are cleared on entry.
  - WARMUP: strobed samples are discarded and counted. After the WARMUP-th sample, go to COLLECT on the next cycle.
  - COLLECT: each strobed sample is pushed if not full. If full, the sample is dropped but the repetition test still runs.
  - WARMUP or COLLECT -> IDLE when i_enable=0, taking effect the next cycle. FIFO contents are retained.
  - WARMUP or COLLECT -> FAULT on a trip. The tripping sample is not pushed. FIFO is flushed (count=0) on the same edge. o_fault=1.
  - FAULT -> WARMUP on i_fault_clr, or -> IDLE if i_enable=0 at that time. o_fault clears on the same edge.
  - FAULT ignores i_rd_ack and all samples.
  - i_fault_clr outside FAULT is ignored.
  - Trip and i_enable=0 in the same cycle: the fault wins.
- FIFO:
  - Circular buffer with wrap-around pointers.
  - o_rd_data is registered and shows the head byte.
  - Latency: a byte pushed at edge N is visible with o_rd_valid=1 after edge N+1.
  - i_rd_ack with o_rd_valid=1 pops one entry; the next head appears the cycle after the ack.
  - i_rd_ack while empty is ignored; no underflow.
  - Push and pop in the same cycle: both take effect and the count is unchanged. Allowed when full: the pop frees a slot.
- Ordering: bytes are read in push order. No byte is duplicated or lost except through full-drop or fault flush.
- Reset asserted mid-operation returns everything to reset values on the next edge, regardless of state.

Test Plan:
1. Reset, enable with an incrementing i_data; SAMPLE_DIV=8, WARMUP=32 -> first push about 264 clocks after enable, 16 bytes with no repeats. o_full=1 and o_count=16, then further samples dropped.
2. Drain a full FIFO with one ack every 3 cycles -> 16 bytes in strict push order, o_rd_valid=0 after the last pop. An extra ack while empty leaves o_count=0.
3. Hold i_data=0xA5 constant in COLLECT -> fault on the 4th equal sample. o_fault=1, o_state=3, o_count=0, tripping byte absent. i_fault_clr -> o_state=1, o_fault=0.
4. Feed the pattern A5,A5,A5,5A,A5 with REP_LIMIT=4 -> no fault, because rep resets on 5A.
5. With the FIFO full, assert ack on a strobe cycle -> o_count stays 16, the new byte lands at the tail, and the read order is preserved.
6. Assert i_reset in COLLECT with o_count=7 -> next cycle all outputs 0 and o_state=0. Deassert i_enable mid-COLLECT -> IDLE with o_count unchanged.

Source files
------------

// File: rtl/entropy_reader.sv
// Entropy reader: decimates the random generator byte stream, discards a warm-up run,
// applies a repetition-count health test and buffers accepted bytes for a valid/ack reader.
module entropy_reader #(
  parameter int DEPTH      = 16,
  parameter int SAMPLE_DIV = 8,
  parameter int WARMUP     = 32,
  parameter int REP_LIMIT  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic [7:0]               i_data,
  input  logic                     i_rd_ack,
  input  logic                     i_fault_clr,
  output logic [7:0]               o_rd_data,
  output logic                     o_rd_valid,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_fault,
  output logic [1:0]               o_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(SAMPLE_DIV);
  localparam int WW = $clog2(WARMUP + 1);
  localparam int RW = $clog2(REP_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARM    = 2'd1,
    COLLECT = 2'd2,
    FAULT   = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [DW-1:0]   div;
  logic [WW-1:0]   warm_cnt;
  logic [RW-1:0]   rep;
  logic [7:0]      prev;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [7:0]      rd_data;
  logic            rd_valid;
  logic            full;
  logic            fault;

  logic            running;
  logic            strobe;
  logic [RW-1:0]   rep_next;
  logic            trip;
  logic            warm_done;
  logic            pop;
  logic            push;
  logic            restart;
  logic [CW-1:0]   count_next;
  logic [CW-1:0]   head_left;
  logic [AW-1:0]   head_idx;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a health-test trip outranks disable and warm-up completion
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (i_enable) state_next = WARM;
        else          state_next = IDLE;
      end
      WARM: begin
        if (trip)           state_next = FAULT;
        else if (!i_enable) state_next = IDLE;
        else if (warm_done) state_next = COLLECT;
        else                state_next = WARM;
      end
      COLLECT: begin
        if (trip)           state_next = FAULT;
        else if (!i_enable) state_next = IDLE;
        else                state_next = COLLECT;
      end
      FAULT: begin
        if (i_fault_clr) state_next = i_enable ? WARM : IDLE;
        else             state_next = FAULT;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control decode: sample strobe, health test and FIFO push/pop qualifiers
  always_comb begin
    running   = (state == WARM) || (state == COLLECT);
    strobe    = running && (div == DW'(SAMPLE_DIV - 1));
    if (i_data == prev) rep_next = rep + RW'(1);
    else                rep_next = RW'(1);
    trip      = strobe && (rep_next >= RW'(REP_LIMIT));
    warm_done = strobe && (warm_cnt == WW'(WARMUP - 1));
    pop       = i_rd_ack && rd_valid && (state != FAULT);
    push      = strobe && (state == COLLECT) && !trip && ((count != CW'(DEPTH)) || pop);
    restart   = (state_next == WARM) && !running;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
    // Bytes already stored before this edge become visible; a fresh push shows up one edge later
    head_left = count - CW'(pop);
    head_idx  = rd_ptr + AW'(pop);
  end

  // Sampling datapath: divider, warm-up counter and repetition tracking
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      div      <= '0;
      warm_cnt <= '0;
      rep      <= '0;
      prev     <= 8'h00;
    end else begin
      if (running && ((state_next == WARM) || (state_next == COLLECT))) begin
        div <= strobe ? '0 : div + DW'(1);
      end else begin
        div <= '0;
      end
      if (strobe) begin
        prev <= i_data;
        rep  <= rep_next;
        if (state == WARM) warm_cnt <= warm_cnt + WW'(1);
      end else if (restart) begin
        warm_cnt <= '0;
        rep      <= '0;
      end
    end
  end

  // FIFO storage
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  // FIFO pointers, occupancy and registered read/status outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
      full     <= 1'b0;
      fault    <= 1'b0;
    end else begin
      fault <= (state_next == FAULT);
      if (trip) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        rd_data  <= 8'h00;
        rd_valid <= 1'b0;
        full     <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count    <= count_next;
        full     <= (count_next == CW'(DEPTH));
        rd_valid <= (head_left != '0);
        rd_data  <= (head_left != '0) ? mem[head_idx] : 8'h00;
      end
    end
  end

  assign o_rd_data  = rd_data;
  assign o_rd_valid = rd_valid;
  assign o_count    = count;
  assign o_full     = full;
  assign o_fault    = fault;
  assign o_state    = state;

endmodule

// File: tb/tb_entropy_reader.sv
// Self-checking bench for entropy_reader: a queue-based reference model feeds a scoreboard
// that a negedge monitor checks against the DUT every cycle.
module tb_entropy_reader;

  localparam int DEPTH = 16;
  localparam int SD    = 8;
  localparam int WU    = 32;
  localparam int REP   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       ack = 1'b0;
  logic       fclr = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [4:0] count;
  logic       full;
  logic       fault;
  logic [1:0] state;

  entropy_reader #(.DEPTH(DEPTH), .SAMPLE_DIV(SD), .WARMUP(WU), .REP_LIMIT(REP)) dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_data(din), .i_rd_ack(ack),
    .i_fault_clr(fclr), .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_count(count),
    .o_full(full), .o_fault(fault), .o_state(state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: mode 0 idle, 1 warm-up, 2 collect, 3 fault; sb holds the FIFO contents in push order
  logic [7:0] sb[$];
  int         m_mode = 0, m_phase = 0, m_warm = 0, m_run = 0;
  logic [7:0] m_prev = 8'h00;
  bit         m_valid = 1'b0;
  bit         started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit pop, running, strobe, trip, push;
    int cnt_old, nmode;
    if (rst) begin
      m_mode = 0; m_phase = 0; m_warm = 0; m_run = 0; m_prev = 8'h00;
      m_valid = 1'b0;
      sb.delete();
      return;
    end
    // the monitor already removed a popped byte from sb at the preceding negedge
    pop     = ack && m_valid && (m_mode != 3);
    cnt_old = sb.size() + (pop ? 1 : 0);
    running = (m_mode == 1) || (m_mode == 2);
    strobe  = running && (m_phase == SD - 1);
    trip    = 1'b0;
    if (strobe) begin
      m_run  = (din == m_prev) ? m_run + 1 : 1;
      m_prev = din;
      trip   = (m_run >= REP);
    end
    nmode = m_mode;
    case (m_mode)
      0: if (en) nmode = 1;
      1: begin
        if (trip) nmode = 3;
        else if (!en) nmode = 0;
        else if (strobe && (m_warm + 1 == WU)) nmode = 2;
      end
      2: begin
        if (trip) nmode = 3;
        else if (!en) nmode = 0;
      end
      default: if (fclr) nmode = en ? 1 : 0;
    endcase
    push = strobe && (m_mode == 2) && !trip && ((cnt_old < DEPTH) || pop);
    if (strobe && (m_mode == 1)) m_warm++;
    if ((nmode == 1) && !running) begin
      m_warm = 0;
      m_run  = 0;
    end
    m_phase = (running && (nmode == 1 || nmode == 2)) ? (strobe ? 0 : m_phase + 1) : 0;
    if (trip) begin
      sb.delete();
      m_valid = 1'b0;
    end else begin
      m_valid = (sb.size() > 0);
      if (push) sb.push_back(din);
    end
    m_mode = nmode;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    started = 1'b1;
  end

  // Monitor: compares every status output, checks the head byte and retires it on an accepted ack
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("state", state, m_mode);
      chk("count", count, sb.size());
      chk("full", full, sb.size() == DEPTH);
      chk("fault", fault, m_mode == 3);
      chk("rd_valid", rd_valid, m_valid);
      if (m_valid && sb.size() > 0) begin
        chk("rd_data", rd_data, sb[0]);
        if (ack && !rst && (m_mode != 3)) void'(sb.pop_front());
      end
    end
  end

  // dmode: 0 = incrementing data, 1 = hold, 2 = random with a small alphabet
  task automatic run(input int n, input int dmode);
    for (int i = 0; i < n; i++) begin
      case (dmode)
        0:       din = din + 8'd1;
        2:       din = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
        default: din = din;
      endcase
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input int dmode);
    int k = 0;
    while (state != s && k < budget) begin
      run(1, dmode);
      k++;
    end
    chk("wait_state", state, s);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      ack = 1'b1;
      run(1, 1);
      ack = 1'b0;
      run(2, 1);
    end
  endtask

  initial begin
    int i;
    logic [7:0] pat [8];
    pat = '{8'h5A, 8'hA5, 8'hA5, 8'hA5, 8'h5A, 8'hA5, 8'hA5, 8'hA5};

    // Reset values
    run(3, 0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_count", count, 5'd0);
    chk("rst_state", state, 2'd0);
    rst = 1'b0;

    // 1: warm-up latency, fill to full, further samples dropped
    en = 1'b1;
    i = 0;
    while (count == 5'd0 && i < 400) begin
      run(1, 0);
      i++;
    end
    chk("first_push_latency", i, 1 + SD * (WU + 1));
    run((DEPTH + 3) * SD, 0);
    chk("fill_full", full, 1'b1);
    chk("fill_count", count, 5'd16);

    // 6b + 2: disable keeps contents; drain one ack every 3 cycles plus extra acks while empty
    en = 1'b0;
    run(2, 1);
    chk("disable_state", state, 2'd0);
    chk("disable_count", count, 5'd16);
    drain(DEPTH + 2);
    chk("drain_count", count, 5'd0);
    chk("drain_valid", rd_valid, 1'b0);

    // 3: constant byte trips the health test; fault clear returns to warm-up
    en = 1'b1;
    wait_state(2'd2, 400, 0);
    din = 8'hA5;
    run(SD, 1);
    wait_state(2'd3, 6 * SD, 1);
    chk("fault_flag", fault, 1'b1);
    chk("fault_count", count, 5'd0);
    fclr = 1'b1;
    run(1, 0);
    fclr = 1'b0;
    chk("clr_state", state, 2'd1);
    chk("clr_fault", fault, 1'b0);

    // 4: repetition run broken by a different byte does not trip
    wait_state(2'd2, 400, 0);
    for (int p = 0; p < 8; p++) begin
      din = pat[p];
      run(SD, 1);
    end
    chk("pattern_no_fault", fault, 1'b0);

    // 5: ack on a strobe cycle with a full FIFO keeps the count at DEPTH
    i = 0;
    while (!full && i < 30 * SD) begin
      run(1, 0);
      i++;
    end
    chk("full_again", full, 1'b1);
    i = 0;
    while (!(m_mode == 2 && m_phase == SD - 1) && i < 2 * SD) begin
      run(1, 0);
      i++;
    end
    ack = 1'b1;
    run(1, 0);
    ack = 1'b0;
    chk("full_pushpop_count", count, 5'd16);
    en = 1'b0;
    drain(DEPTH + 1);
    chk("drain2_count", count, 5'd0);

    // 6a: reset in COLLECT with seven bytes stored
    en = 1'b1;
    i = 0;
    while (count != 5'd7 && i < 600) begin
      run(1, 0);
      i++;
    end
    chk("pre_reset_count", count, 5'd7);
    rst = 1'b1;
    run(1, 0);
    chk("mid_rst_count", count, 5'd0);
    chk("mid_rst_state", state, 2'd0);
    chk("mid_rst_valid", rd_valid, 1'b0);
    chk("mid_rst_data", rd_data, 8'h00);
    chk("mid_rst_full", full, 1'b0);
    chk("mid_rst_fault", fault, 1'b0);
    rst = 1'b0;

    // Randomized traffic against the model
    en = 1'b1;
    for (int k = 0; k < 5000; k++) begin
      ack  = ($urandom_range(0, 2) == 0);
      fclr = ($urandom_range(0, 39) == 0);
      rst  = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 299) == 0) en = ~en;
      run(1, ($urandom_range(0, 1) == 0) ? 2 : 0);
    end
    ack = 1'b0;
    fclr = 1'b0;
    rst = 1'b0;
    run(4, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
    $fatal(1);
  end

endmodule
